product_accumulator: RTL and testbench

Sequential stage directly downstream of the 4-bit combinational multiplier. It accepts 8-bit products over a valid/ready handshake, sums a fixed block of N products into a wider accumulator, and presents each block sum with an overflow flag on a second valid/ready handshake. It turns the multiplier into a multiply-accumulate path for dot products of 4-bit vectors.

---
 rtl/product_accumulator.sv | 158 +++++++++++++++
 tb/tb_product_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums blocks of N multiplier products into an AW-bit result with a sticky overflow flag.
// Optional feature: define PRODUCT_ACCUMULATOR_SAT_EN to clamp the sum at 2^AW-1 instead of wrapping.
module product_accumulator #(
    parameter int PW = 8,
    parameter int AW = 12,
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] p_in,
    input  logic          p_valid,
    output logic          p_ready,
    input  logic          clear,
    output logic [AW-1:0] acc_out,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic          ovf
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] r_acc_out;
    logic [AW-1:0] w_acc_next;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_p_ready;
    logic          w_acc_valid;
    logic          w_accept;
    logic          w_consume;
    logic          w_last;
    logic [AW:0]   w_sum;

    // clear outranks both handshakes, so a product or consume in a clear cycle is void
    assign w_accept  = p_valid & w_p_ready & ~clear;
    assign w_consume = w_acc_valid & acc_ready & ~clear;
    assign w_last    = (r_count == CW'(N - 1));
    assign w_sum     = {1'b0, r_acc} + {{(AW - PW + 1){1'b0}}, p_in};

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    // Saturating add: once the block has overflowed the sum stays pinned at full scale
    always_comb begin
        w_acc_next = w_sum[AW-1:0];
        if (w_sum[AW] || r_ovf) begin
            w_acc_next = '1;
        end else begin
            w_acc_next = w_sum[AW-1:0];
        end
    end
`else
    // Wrapping add: the carry only feeds the sticky flag
    always_comb begin
        w_acc_next = w_sum[AW-1:0];
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept && w_last) begin
                        w_next_state = ST_HOLD;
                    end else begin
                        w_next_state = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (acc_ready) begin
                        w_next_state = ST_ACCUM;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
                default: w_next_state = ST_ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        w_p_ready   = 1'b1;
        w_acc_valid = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_p_ready   = 1'b1;
                w_acc_valid = 1'b0;
            end
            ST_HOLD: begin
                w_p_ready   = 1'b0;
                w_acc_valid = 1'b1;
            end
            default: begin
                w_p_ready   = 1'b1;
                w_acc_valid = 1'b0;
            end
        endcase
    end

    // Accumulator, product counter, sticky overflow and held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
        end else if (clear) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_sum[AW];
            if (w_last) begin
                r_acc_out <= w_acc_next;
                r_count   <= '0;
            end else begin
                r_acc_out <= r_acc_out;
                r_count   <= r_count + CW'(1);
            end
        end else if (w_consume) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_count   <= r_count;
            r_acc_out <= r_acc_out;
        end else begin
            r_acc     <= r_acc;
            r_count   <= r_count;
            r_ovf     <= r_ovf;
            r_acc_out <= r_acc_out;
        end
    end

    assign p_ready   = w_p_ready;
    assign acc_valid = w_acc_valid;
    assign acc_out   = r_acc_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 12-bit and a 9-bit instance share one stimulus stream.
// Overflow expectations follow PRODUCT_ACCUMULATOR_SAT_EN.
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic [7:0]  p_in;
    logic        p_valid;
    logic        clear;
    logic        acc_ready;
    logic        p_ready_a;
    logic        acc_valid_a;
    logic [11:0] acc_out_a;
    logic        ovf_a;
    logic        p_ready_b;
    logic        acc_valid_b;
    logic [8:0]  acc_out_b;
    logic        ovf_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    localparam logic [31:0] EXP_OVF_SUM = 32'd511;
`else
    localparam logic [31:0] EXP_OVF_SUM = 32'd388;
`endif

    product_accumulator #(.PW(8), .AW(12), .N(4)) u_dut_a (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready_a),
        .clear(clear), .acc_out(acc_out_a), .acc_valid(acc_valid_a),
        .acc_ready(acc_ready), .ovf(ovf_a)
    );

    product_accumulator #(.PW(8), .AW(9), .N(4)) u_dut_b (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready_b),
        .clear(clear), .acc_out(acc_out_b), .acc_valid(acc_valid_b),
        .acc_ready(acc_ready), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] v);
        p_in    = v;
        p_valid = 1'b1;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        p_in      = 8'd0;
        p_valid   = 1'b0;
        clear     = 1'b0;
        acc_ready = 1'b1;
        #7;
        check("rst_p_ready", 32'(p_ready_a), 32'd1);
        check("rst_acc_valid", 32'(acc_valid_a), 32'd0);
        check("rst_acc_out", 32'(acc_out_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b0;
        tick();

        // Continuous block, consumer always ready
        feed(8'd24);
        check("t1_p_ready_1", 32'(p_ready_a), 32'd1);
        feed(8'd27);
        check("t1_p_ready_2", 32'(p_ready_a), 32'd1);
        feed(8'd225);
        check("t1_p_ready_3", 32'(p_ready_a), 32'd1);
        check("t1_valid_early", 32'(acc_valid_a), 32'd0);
        feed(8'd100);
        p_valid = 1'b0;
        check("t1_acc_valid", 32'(acc_valid_a), 32'd1);
        check("t1_acc_out", 32'(acc_out_a), 32'd376);
        check("t1_ovf", 32'(ovf_a), 32'd0);
        check("t1_p_ready_hold", 32'(p_ready_a), 32'd0);
        check("t1_acc_out_b", 32'(acc_out_b), 32'd376);
        tick();
        check("t1_valid_one_cycle", 32'(acc_valid_a), 32'd0);
        check("t1_p_ready_back", 32'(p_ready_a), 32'd1);

        // Same products with two idle cycles between each; p_in garbage while idle
        for (int i = 0; i < 4; i++) begin
            logic [7:0] prod [4];
            prod = '{8'd24, 8'd27, 8'd225, 8'd100};
            feed(prod[i]);
            p_valid = 1'b0;
            p_in    = 8'd255;
            if (i < 3) begin
                tick();
                tick();
                check("t2_gap_valid", 32'(acc_valid_a), 32'd0);
                check("t2_gap_ready", 32'(p_ready_a), 32'd1);
            end else begin
                check("t2_acc_valid", 32'(acc_valid_a), 32'd1);
                check("t2_acc_out", 32'(acc_out_a), 32'd376);
            end
        end
        tick();
        check("t2_consumed", 32'(acc_valid_a), 32'd0);

        // Backpressure: result held for 5 cycles while products are offered
        acc_ready = 1'b0;
        feed(8'd10);
        feed(8'd20);
        feed(8'd30);
        feed(8'd40);
        p_in = 8'd7;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_out", 32'(acc_out_a), 32'd100);
            check("t3_hold_valid", 32'(acc_valid_a), 32'd1);
            check("t3_hold_p_ready", 32'(p_ready_a), 32'd0);
            tick();
        end
        p_valid   = 1'b0;
        acc_ready = 1'b1;
        tick();
        check("t3_release_p_ready", 32'(p_ready_a), 32'd1);
        check("t3_release_valid", 32'(acc_valid_a), 32'd0);
        feed(8'd1);
        feed(8'd2);
        feed(8'd3);
        feed(8'd4);
        p_valid = 1'b0;
        check("t3_next_block", 32'(acc_out_a), 32'd10);
        tick();

        // Overflow on the 9-bit instance, then a clean block
        feed(8'd225);
        feed(8'd225);
        feed(8'd225);
        feed(8'd225);
        p_valid = 1'b0;
        check("t4_ovf_sum_b", 32'(acc_out_b), EXP_OVF_SUM);
        check("t4_ovf_flag_b", 32'(ovf_b), 32'd1);
        check("t4_sum_a", 32'(acc_out_a), 32'd900);
        check("t4_ovf_a", 32'(ovf_a), 32'd0);
        tick();
        feed(8'd1);
        feed(8'd1);
        feed(8'd1);
        feed(8'd1);
        p_valid = 1'b0;
        check("t4_clean_sum_b", 32'(acc_out_b), 32'd4);
        check("t4_clean_ovf_b", 32'(ovf_b), 32'd0);
        tick();

        // clear mid-block drops the partial sum and the product offered with it
        feed(8'd24);
        feed(8'd27);
        clear = 1'b1;
        feed(8'd100);
        clear     = 1'b0;
        acc_ready = 1'b0;
        feed(8'd3);
        feed(8'd3);
        feed(8'd3);
        feed(8'd3);
        p_valid = 1'b0;
        check("t5_after_clear", 32'(acc_out_a), 32'd12);
        check("t5_hold_valid", 32'(acc_valid_a), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clear_hold_valid", 32'(acc_valid_a), 32'd0);
        check("t5_clear_hold_out", 32'(acc_out_a), 32'd0);
        check("t5_clear_hold_ready", 32'(p_ready_a), 32'd1);

        // Asynchronous reset mid-block
        acc_ready = 1'b1;
        feed(8'd24);
        feed(8'd27);
        p_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_mid_ready", 32'(p_ready_a), 32'd1);
        check("t6_rst_mid_valid", 32'(acc_valid_a), 32'd0);
        rst = 1'b0;

        // Asynchronous reset while holding a result
        acc_ready = 1'b0;
        feed(8'd24);
        feed(8'd27);
        feed(8'd225);
        feed(8'd100);
        p_valid = 1'b0;
        check("t6_pre_rst_out", 32'(acc_out_a), 32'd376);
        check("t6_pre_rst_valid", 32'(acc_valid_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_hold_valid", 32'(acc_valid_a), 32'd0);
        check("t6_rst_hold_ready", 32'(p_ready_a), 32'd1);
        check("t6_rst_hold_out", 32'(acc_out_a), 32'd0);
        check("t6_rst_hold_ovf", 32'(ovf_a), 32'd0);
        rst       = 1'b0;
        acc_ready = 1'b1;
        feed(8'd24);
        feed(8'd27);
        feed(8'd225);
        feed(8'd100);
        p_valid = 1'b0;
        check("t6_after_rst_out", 32'(acc_out_a), 32'd376);
        check("t6_after_rst_valid", 32'(acc_valid_a), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
